// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: requester, FIFO and consumer signals of the push arbiter.
// FIFO_ARB_SOURCE_ID_EN widens the FIFO data by id_w bits and adds out_id.
interface fifo_push_arbiter_if #(
    parameter int n_req = 4,
    parameter int width = 8
);
    localparam int id_w = $clog2(n_req);
`ifdef FIFO_ARB_SOURCE_ID_EN
    localparam int dw = width + id_w;
`else
    localparam int dw = width;
`endif
    logic [n_req-1:0]       req_valid;
    logic [n_req*width-1:0] req_data;
    logic [n_req-1:0]       req_ready;
    logic                   fifo_push;
    logic [dw-1:0]          fifo_write_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [dw-1:0]          fifo_read_data;
    logic                   fifo_pop;
    logic                   out_valid;
    logic                   out_ready;
    logic [width-1:0]       out_data;
`ifdef FIFO_ARB_SOURCE_ID_EN
    logic [id_w-1:0]        out_id;
`endif
    modport slave (
        input  req_valid, req_data, fifo_full, fifo_empty, fifo_read_data, out_ready,
        output req_ready, fifo_push, fifo_write_data, fifo_pop, out_valid, out_data
`ifdef FIFO_ARB_SOURCE_ID_EN
        , output out_id
`endif
    );
    modport master (
        output req_valid, req_data, fifo_full, fifo_empty, fifo_read_data, out_ready,
        input  req_ready, fifo_push, fifo_write_data, fifo_pop, out_valid, out_data
`ifdef FIFO_ARB_SOURCE_ID_EN
        , input out_id
`endif
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-locking arbiter feeding one FIFO write port.
// FIFO_ARB_SOURCE_ID_EN tags each FIFO entry with its source requester id.
module fifo_push_arbiter #(
    parameter int n_req     = 4,
    parameter int width     = 8,
    parameter int max_burst = 4
) (
    input logic clk,
    input logic rst,
    fifo_push_arbiter_if.slave bus
);
    localparam int id_w = $clog2(n_req);
    localparam int cw   = $clog2(max_burst + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          r_state, w_state_nxt;
    logic [id_w-1:0] r_owner, r_rr_ptr, w_owner_nxt, w_rr_ptr_nxt, w_g, w_idx;
    logic [id_w:0]   w_sum;
    logic [cw-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic            w_grant, w_push;

    // Wrap by explicit compare so non-power-of-two n_req rotates correctly
    function automatic logic [id_w-1:0] f_inc(input logic [id_w-1:0] x);
        return (x == id_w'(n_req - 1)) ? '0 : x + id_w'(1);
    endfunction

    always_comb begin
        w_grant = 1'b0;
        w_g     = r_owner;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = n_req - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (id_w + 1)'(k);
            w_idx = (w_sum >= (id_w + 1)'(n_req)) ? id_w'(w_sum - (id_w + 1)'(n_req)) : id_w'(w_sum);
            if (bus.req_valid[w_idx]) begin
                w_grant = 1'b1;
                w_g     = w_idx;
            end
        end
        if (r_state == BURST) begin
            w_grant = bus.req_valid[r_owner];
            w_g     = r_owner;
        end
    end

    assign w_push        = w_grant & ~bus.fifo_full & ~rst;
    assign bus.fifo_push = w_push;
    assign bus.req_ready = w_push ? n_req'(1) << w_g : '0;
`ifdef FIFO_ARB_SOURCE_ID_EN
    assign bus.fifo_write_data = {w_g, bus.req_data[w_g*width +: width]};
    assign bus.out_id          = bus.fifo_read_data[width +: id_w];
`else
    assign bus.fifo_write_data = bus.req_data[w_g*width +: width];
`endif
    assign bus.out_valid = ~bus.fifo_empty;
    assign bus.fifo_pop  = ~bus.fifo_empty & bus.out_ready & ~rst;
    assign bus.out_data  = bus.fifo_read_data[width-1:0];

    // A full FIFO freezes every piece of arbitration state
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        if (r_state == IDLE) begin
            if (w_push && max_burst == 1) begin
                w_rr_ptr_nxt = f_inc(w_g);
            end else if (w_push) begin
                w_state_nxt    = BURST;
                w_owner_nxt    = w_g;
                w_beat_cnt_nxt = cw'(1);
            end
        end else if (!bus.fifo_full) begin
            if (!w_grant || r_beat_cnt + cw'(1) == cw'(max_burst)) begin
                w_state_nxt    = IDLE;
                w_rr_ptr_nxt   = f_inc(r_owner);
                w_beat_cnt_nxt = '0;
            end else begin
                w_beat_cnt_nxt = r_beat_cnt + cw'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: random requesters against a reference model, on a 4-req/burst-4
// and a 3-req/burst-1 instance; honours FIFO_ARB_SOURCE_ID_EN when defined.
module tb_fifo_push_arbiter;
    localparam int W = 8;
`ifdef FIFO_ARB_SOURCE_ID_EN
    localparam int DW = W + 2;
`else
    localparam int DW = W;
`endif
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.n_req(4), .width(W)) b0 ();
    fifo_push_arbiter_if #(.n_req(3), .width(W)) b1 ();
    fifo_push_arbiter #(.n_req(4), .width(W), .max_burst(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    fifo_push_arbiter #(.n_req(3), .width(W), .max_burst(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int checks = 0;
    int errors = 0;
    int nr[2] = '{4, 3};
    int mb[2] = '{4, 1};
    int own[2], cnt[2], ptr[2];
    logic [3:0]   pv[2];
    logic [W-1:0] pd[2][4];
    logic         full, empty, ordy;
    logic [DW-1:0] rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // own<0 means no burst is held; otherwise the requester locked in
    function automatic int egrant(input int d, input logic [3:0] v);
        if (own[d] >= 0) return v[own[d]] ? own[d] : -1;
        for (int k = 0; k < nr[d]; k++)
            if (v[(ptr[d] + k) % nr[d]]) return (ptr[d] + k) % nr[d];
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            own[d] = -1;
            cnt[d] = 0;
            ptr[d] = 0;
        end
    endtask

    task automatic model_update(input int d);
        int g;
        g = egrant(d, pv[d]);
        if (full) return;
        if (own[d] >= 0) begin
            if (g < 0 || cnt[d] + 1 == mb[d]) begin
                ptr[d] = (own[d] + 1) % nr[d];
                own[d] = -1;
                cnt[d] = 0;
            end else cnt[d]++;
        end else if (g >= 0) begin
            if (mb[d] == 1) ptr[d] = (g + 1) % nr[d];
            else begin
                own[d] = g;
                cnt[d] = 1;
            end
        end
        if (g >= 0) pv[d][g] = 1'b0;
    endtask

    task automatic drive();
        b0.req_valid = pv[0];
        b0.req_data  = {pd[0][3], pd[0][2], pd[0][1], pd[0][0]};
        b1.req_valid = pv[1][2:0];
        b1.req_data  = {pd[1][2], pd[1][1], pd[1][0]};
        b0.fifo_full = full;
        b1.fifo_full = full;
        b0.fifo_empty = empty;
        b1.fifo_empty = empty;
        b0.out_ready = ordy;
        b1.out_ready = ordy;
        b0.fifo_read_data = rdata;
        b1.fifo_read_data = rdata;
    endtask

    // mode: 0 no new requests, 1 every idle requester raises, 2 random raise
    task automatic step(input int mode, input bit rnd_full, input int exp_src);
        int g;
        logic [63:0] wd, ewd;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < nr[d]; i++)
                if (!pv[d][i] && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1))) begin
                    pv[d][i] = 1'b1;
                    pd[d][i] = W'($urandom);
                end
        full  = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        empty = 1'($urandom_range(0, 1));
        ordy  = 1'($urandom_range(0, 1));
        rdata = DW'($urandom);
        drive();
        #1;
        for (int d = 0; d < 2; d++) begin
            g = egrant(d, pv[d]);
            wd = (d == 0) ? 64'(b0.fifo_write_data) : 64'(b1.fifo_write_data);
            chk(d == 0 ? "ready0" : "ready1", d == 0 ? 64'(b0.req_ready) : 64'(b1.req_ready),
                (g >= 0 && !full) ? 64'(1) << g : 64'(0));
            chk(d == 0 ? "push0" : "push1", d == 0 ? 64'(b0.fifo_push) : 64'(b1.fifo_push),
                64'(g >= 0 && !full));
            if (g >= 0 && !full) begin
`ifdef FIFO_ARB_SOURCE_ID_EN
                ewd = (64'(g) << W) | 64'(pd[d][g]);
`else
                ewd = 64'(pd[d][g]);
`endif
                chk(d == 0 ? "wdata0" : "wdata1", wd, ewd);
            end
        end
        if (exp_src >= 0) chk("seq", 64'(b0.req_ready), 64'(1) << exp_src);
        chk("out_valid", 64'(b0.out_valid), 64'(!empty));
        chk("pop0", 64'(b0.fifo_pop), 64'(!empty && ordy));
        chk("pop1", 64'(b1.fifo_pop), 64'(!empty && ordy));
        chk("out_data", 64'(b0.out_data), 64'(rdata[W-1:0]));
`ifdef FIFO_ARB_SOURCE_ID_EN
        chk("out_id", 64'(b0.out_id), 64'(rdata >> W));
`endif
        @(posedge clk);
        model_update(0);
        model_update(1);
    endtask

    task automatic rst_check();
        empty = 1'b0;
        ordy  = 1'b1;
        full  = 1'b0;
        drive();
        #1;
        chk("rst_ready0", 64'(b0.req_ready), 64'(0));
        chk("rst_push0", 64'(b0.fifo_push), 64'(0));
        chk("rst_ready1", 64'(b1.req_ready), 64'(0));
        chk("rst_pop0", 64'(b0.fifo_pop), 64'(0));
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        rst_check();
    endtask

    initial begin
        rst = 1'b1;
        rdata = '0;
        for (int d = 0; d < 2; d++) begin
            pv[d] = 4'hF;
            for (int i = 0; i < 4; i++) pd[d][i] = W'(16 * i + d);
        end
        #1;
        rst_check();
        for (int k = 0; k < 17; k++) step(1, 1'b0, (k / 4) % 4);
        rst_pulse();
        pv[0] = 4'b1000;
        step(0, 1'b0, 3);
        pv[0][3] = 1'b1;
        step(0, 1'b0, 3);
        pv[0][3] = 1'b1;
        rst_pulse();
        pv[0] = 4'b1001;
        step(0, 1'b0, 0);
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 75) rst_pulse();
            step(2, 1'b1, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

- Round-robin arbiter with burst locking that shares a single flip-flop FIFO write port between `n_req` valid/ready requesters.
- Drives FIFO `push`/`write_data` from its own grant state and back-pressures requesters from FIFO `full`.
- Exposes the FIFO read side as a valid/ready stream to one consumer.
- Sits between several producer blocks and one FIFO instance.

## Interface
Parameters:
- `n_req`, 4, number of requesters (≥2); `id_w = $clog2(n_req)`
- `width`, 8, payload width per requester
- `max_burst`, 4, max consecutive beats one requester may push before it must release (≥1)

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `req_valid` in `n_req` — requester i has data
- `req_data` in `n_req*width` — requester i at `[i*width +: width]`
- `req_ready` out `n_req` — one-hot or zero; beat i transfers when `req_valid[i] & req_ready[i]`
- `fifo_push` out 1 — to FIFO `push`
- `fifo_write_data` out `width` (`width+id_w` with macro) — to FIFO `write_data`
- `fifo_full` in 1 — from FIFO `full`
- `fifo_empty` in 1 — from FIFO `empty`
- `fifo_read_data` in `width` (`width+id_w` with macro) — from FIFO `read_data`
- `fifo_pop` out 1 — to FIFO `pop`
- `out_valid` out 1 — consumer stream valid
- `out_ready` in 1 — consumer stream ready
- `out_data` out `width` — consumer payload
- `out_id` out `id_w` — source requester (macro only)

## Operation
- State: `state` ∈ {IDLE, BURST}, `owner` (`id_w`), `rr_ptr` (`id_w`), `beat_cnt` (`$clog2(max_burst+1)`).
- IDLE grant: first i with `req_valid[i]=1`, searching `rr_ptr, rr_ptr+1, …` modulo `n_req`; none → no grant.
- BURST grant: `owner` if `req_valid[owner]=1`, else no grant. No other requester is granted in BURST.
- `req_ready[g] = ~fifo_full` for granted g; all other bits 0. `fifo_push = granted & ~fifo_full`.
- `fifo_write_data = req_data[g]`; with macro `{g, req_data[g]}` (ID in MSBs). Value is don't-care when `fifo_push=0`.

Transitions on a push from g in IDLE:
- `max_burst=1`: stay IDLE, `rr_ptr <= g+1 mod n_req`.
- Otherwise: `owner <= g`, `beat_cnt <= 1`, go BURST.

Transitions in BURST:
- Push with `beat_cnt+1 == max_burst`: go IDLE, `rr_ptr <= owner+1`, `beat_cnt <= 0`.
- Push otherwise: `beat_cnt++`.
- `req_valid[owner]=0`: go IDLE, `rr_ptr <= owner+1`, `beat_cnt <= 0`. This costs a one-cycle grant bubble.

Other rules:
- `fifo_full=1` stalls. `state`, `owner`, `rr_ptr` and `beat_cnt` hold, so a full FIFO never ends a burst or rotates priority.
- `n_req` not a power of two: wrap uses explicit compare to `n_req-1`, not bit overflow.
- Read side: `out_valid = ~fifo_empty`, `fifo_pop = out_valid & out_ready`, `out_data = fifo_read_data[width-1:0]`.
- Simultaneous push and pop are independent. They are legal even when the FIFO is full, but the arbiter still gates push on `fifo_full`.

## Timing
- All grant/ready/push outputs are combinational from registered state plus `req_valid` and `fifo_full`.
- Zero-cycle latency from `req_valid` to `req_ready` when granted.
- A beat appears at FIFO `read_data` per the FIFO's own latency, with no added arbiter latency.
- Reset, asynchronous: `state=IDLE`, `rr_ptr=0`, `owner=0`, `beat_cnt=0`.
- While `rst=1`: `req_ready=0` and `fifo_push=0` (forced); `fifo_pop=0`.
- `rst` asserted mid-burst aborts the burst. No partial state survives, and the first grant after reset starts at requester 0.
- Requesters must hold `req_valid`/`req_data` stable until accepted. The arbiter does not check this.

## Configuration
- Macro `FIFO_ARB_SOURCE_ID_EN`.
- Defined:
  - `fifo_write_data`/`fifo_read_data` are `width+id_w` wide, carrying `{src_id, data}`.
  - Port `out_id = fifo_read_data[width +: id_w]` exists.
- Undefined:
  - Both FIFO data ports are `width` wide.
  - No `out_id` port, and no ID logic is synthesized.

## Test plan
- Reset, then all 4 `req_valid=1`, `fifo_full=0`, `max_burst=4` → pushes from req0 ×4, req1 ×4, req2 ×4, req3 ×4, then req0 again; no bubbles between bursts.
- req2 alone valid for 2 beats then drops → 2 pushes from 2, one idle cycle, then `rr_ptr=3`; req1 and req3 now valid → req3 granted first.
- req1 bursting, `fifo_full=1` for 5 cycles after beat 2 → `req_ready=0`, `fifo_push=0` during the stall; beats 3–4 from req1 follow, then release.
- `max_burst=1`, req0 and req1 always valid → strict alternation 0,1,0,1; with macro, `out_id` sequence is 0,1,0,1 as the consumer pops.
- `rst` pulsed mid-burst on owner 3 → outputs go 0 immediately; after release, req3 and req0 both valid → req0 granted.
- `fifo_empty=0`, `out_ready` toggling 1,0,1 → `fifo_pop` equals `out_ready` each cycle; `fifo_empty=1` → `fifo_pop=0` regardless of `out_ready`.
